// File: rtl/apb_pkg.sv
// Shared APB definitions: completer FSM states, pprot/address bit positions and
// response codes used by both the master and completer sides of the bridge.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } apb_slv_state_e;

    localparam int PPROT_NONSEC_BIT = 1;
    localparam int ADDR_LSB         = 2;

    localparam logic OKAY   = 1'b0;
    localparam logic SLVERR = 1'b1;

endpackage

// File: rtl/apb_reg_bank.sv
// Register storage for the APB completer: byte-lane writes, a combinational
// read port and a flattened view of every register for downstream fabric.
module apb_reg_bank #(
    parameter int regNum    = 16,
    parameter int dataWidth = 32,
    parameter int idxWidth  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          writeEn,
    input  logic [idxWidth-1:0]           writeIdx,
    input  logic [dataWidth-1:0]          writeData,
    input  logic [dataWidth/8-1:0]        writeStrb,
    input  logic [idxWidth-1:0]           readIdx,
    output logic [dataWidth-1:0]          readData,
    output logic [regNum*dataWidth-1:0]   regOut
);

    logic [dataWidth-1:0] regs [regNum];

    // NOTE: this bank is reset because its contents are architecturally visible
    // on regOut from the moment reset releases; plain RAM arrays are not reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < regNum; i++) begin
                regs[i] <= '0;
            end
        end else if (writeEn) begin
            for (int i = 0; i < regNum; i++) begin
                if (writeIdx == idxWidth'(i)) begin
                    for (int k = 0; k < dataWidth / 8; k++) begin
                        if (writeStrb[k]) begin
                            regs[i][8*k +: 8] <= writeData[8*k +: 8];
                        end
                    end
                end
            end
        end
    end

    // Explicit compare mux so an index past regNum reads zero for any regNum.
    always_comb begin
        readData = '0;
        for (int i = 0; i < regNum; i++) begin
            if (readIdx == idxWidth'(i)) begin
                readData = regs[i];
            end
        end
    end

    for (genvar g = 0; g < regNum; g++) begin : g_flat
        assign regOut[g*dataWidth +: dataWidth] = regs[g];
    end

endmodule

// File: rtl/apb_slave_regfile.sv
// APB4 completer terminating bridge transfers into a register bank, with
// programmable wait states, byte strobes, secure-region checks and SLVERR.
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int dataWidth  = 32,
    parameter int addrWidth  = 32,
    parameter int regNum     = 16,
    parameter int waitStates = 1,
    parameter int secureRegs = 4
) (
    input  logic                        pclk,
    input  logic                        preset,
    input  logic                        pselx,
    input  logic                        penable,
    input  logic                        pwrite,
    input  logic [addrWidth-1:0]        paddr,
    input  logic [dataWidth-1:0]        pwdata,
    input  logic [dataWidth/8-1:0]      pstrb,
    input  logic [2:0]                  pprot,
    output logic                        pready,
    output logic                        pslverr,
    output logic [dataWidth-1:0]        prdata,
    output logic [regNum*dataWidth-1:0] regOut
);

    localparam int idxWidth  = (regNum > 1) ? $clog2(regNum) : 1;
    localparam int wordWidth = addrWidth - ADDR_LSB;

    apb_slv_state_e         state, nextState;
    logic [3:0]             counter;
    logic [idxWidth-1:0]    idxQ, readIdx;
    logic [dataWidth-1:0]   wdataQ, readData;
    logic [dataWidth/8-1:0] strbQ;
    logic                   writeQ, errQ;
    logic [wordWidth-1:0]   wordIdx;
    logic                   misaligned, outOfRange, secureViolation;
    logic                   errLive, errSel, writeSel, setup, writeEn;
    logic                   unusedProt;

    assign wordIdx    = paddr[addrWidth-1:ADDR_LSB];
    assign misaligned = |paddr[ADDR_LSB-1:0];
    assign outOfRange = wordIdx >= wordWidth'(regNum);

    if (secureRegs > 0) begin : g_secure
        assign secureViolation = (wordIdx < wordWidth'(secureRegs)) && pprot[PPROT_NONSEC_BIT];
    end else begin : g_noSecure
        assign secureViolation = 1'b0;
    end

    // Only the non-secure bit matters; privileged/instruction bits are ignored.
    assign unusedProt = ^pprot;

    assign errLive = misaligned || outOfRange || secureViolation;
    assign setup   = pselx && !penable;

    // With zero wait states DONE is entered straight from the setup edge, before
    // anything is latched, so the response is built from the live bus.
    assign errSel   = (state == IDLE) ? errLive : errQ;
    assign writeSel = (state == IDLE) ? pwrite : writeQ;
    assign readIdx  = (state == IDLE) ? wordIdx[idxWidth-1:0] : idxQ;

    assign pready  = (state == DONE);
    assign writeEn = (state == DONE) && pselx && penable && writeQ && !errQ;

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statement can leave it unassigned and infer a latch.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: if (setup) nextState = (waitStates == 0) ? DONE : WAIT;
            WAIT: begin
                if (!pselx)            nextState = IDLE;
                else if (counter == 0) nextState = DONE;
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state   <= IDLE;
            counter <= '0;
            idxQ    <= '0;
            wdataQ  <= '0;
            strbQ   <= '0;
            writeQ  <= 1'b0;
            errQ    <= 1'b0;
            pslverr <= OKAY;
            prdata  <= '0;
        end else begin
            state <= nextState;

            if (state == IDLE && setup) begin
                idxQ    <= wordIdx[idxWidth-1:0];
                wdataQ  <= pwdata;
                strbQ   <= pstrb;
                writeQ  <= pwrite;
                errQ    <= errLive;
                counter <= 4'(waitStates - 1);
            end else if (state == WAIT && pselx && counter != 0) begin
                counter <= counter - 4'd1;
            end

            if (nextState == DONE && state != DONE) begin
                pslverr <= errSel ? SLVERR : OKAY;
                prdata  <= (!writeSel && !errSel) ? readData : '0;
            end else if (state == DONE) begin
                pslverr <= OKAY;
                prdata  <= '0;
            end
        end
    end

    apb_reg_bank #(
        .regNum    (regNum),
        .dataWidth (dataWidth),
        .idxWidth  (idxWidth)
    ) u_bank (
        .clk       (pclk),
        .rst       (preset),
        .writeEn   (writeEn),
        .writeIdx  (idxQ),
        .writeData (wdataQ),
        .writeStrb (strbQ),
        .readIdx   (readIdx),
        .readData  (readData),
        .regOut    (regOut)
    );

endmodule
